// File: rtl/cordic_sqrt_range_pkg.sv
// Shared types and constants for the CORDIC sqrt range-reduction wrapper.
// Defaults, output width derivation and FSM encoding.
package cordic_sqrt_range_pkg;

  localparam int XW_DEF   = 32;
  localparam int FRAC_DEF = 8;
  localparam int MW       = 16;
  localparam logic [MW-1:0] SAT = 16'hFFFF;

  function automatic int ow_of(input int xw, input int frac);
    return xw / 2 + frac;
  endfunction

  localparam int OW_DEF = ow_of(XW_DEF, FRAC_DEF);

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    KICK,
    ARM,
    WAIT,
    DNRM,
    DONE
  } state_t;

endpackage

// File: rtl/sqrt_denorm_shift.sv
// Saturate a wrapped core result, then scale it back down by h.
// Purely combinational.
module sqrt_denorm_shift
  import cordic_sqrt_range_pkg::*;
#(
  parameter int OW = OW_DEF,
  parameter int HW = 4
) (
  input  logic [MW-1:0] r,
  input  logic [HW-1:0] h,
  output logic [OW-1:0] q
);

  logic [MW-1:0] rs;
  logic [OW-1:0] wide;

  // sqrt of a mantissa >= 0.25 always has its MSB set
  assign rs   = r[MW-1] ? r : SAT;
  assign wide = {rs, {(OW-MW){1'b0}}};
  assign q    = wide >> h;

endmodule

// File: rtl/cordic_sqrt_range.sv
// Range reduction around a sequential CORDIC sqrt core:
// normalize by even shifts, launch core, denormalize result.
module cordic_sqrt_range
  import cordic_sqrt_range_pkg::*;
#(
  parameter int XW   = XW_DEF,
  parameter int FRAC = FRAC_DEF,
  localparam int OW  = ow_of(XW, FRAC)
) (
  input  logic          clk,
  input  logic          rstx,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_q,
  output logic          core_start,
  output logic [MW-1:0] core_din,
  input  logic          core_busy,
  input  logic [MW-1:0] core_dout
);

  localparam int HW = $clog2(XW / 2);

  state_t        state;
  state_t        nxt;
  logic [XW-1:0] m;
  logic [HW-1:0] h;
  logic [MW-1:0] r;
  logic [OW-1:0] q_dn;
  logic          top0;

  assign top0       = (m[XW-1:XW-2] == 2'b00);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign core_start = (state == KICK);

  sqrt_denorm_shift #(
    .OW(OW),
    .HW(HW)
  ) u_dn (
    .r(r),
    .h(h),
    .q(q_dn)
  );

  always_ff @(posedge clk) begin
    if (!rstx) begin
      state    <= IDLE;
      m        <= '0;
      h        <= '0;
      r        <= '0;
      core_din <= '0;
      out_q    <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m <= in_x;
            h <= '0;
            if (in_x == '0) out_q <= '0;
          end
        end
        NORM: begin
          if (top0) begin
            m <= m << 2;
            h <= h + HW'(1);
          end else begin
            core_din <= m[XW-1 -: MW];
          end
        end
        WAIT: if (!core_busy) r <= core_dout;
        DNRM: out_q <= q_dn;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) nxt = (in_x == '0) ? DONE : NORM;
      end
      NORM: if (!top0) nxt = KICK;
      KICK: nxt = ARM;
      ARM:  nxt = WAIT;
      WAIT: if (!core_busy) nxt = DNRM;
      DNRM: nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

endmodule
